// File: rtl/eth_tx_source_arbiter_if.sv
// Signal bundle between the audio/video frame buffers, the TX scheduler and the
// source arbiter. The master modport is the arbiter side.
interface eth_tx_source_arbiter_if;
    logic        aud_req;
    logic [10:0] aud_len;
    logic        aud_done;
    logic        vid_req;
    logic [10:0] vid_len;
    logic        vid_done;
    logic        sched_new_data;
    logic        sched_audio_video;
    logic [10:0] sched_num_words;
    logic        sched_tx_eof;
    logic        busy;
    logic        timeout_err;
    logic [15:0] frames_sent;

    modport master (
        input  aud_req, aud_len, vid_req, vid_len, sched_tx_eof,
        output aud_done, vid_done, sched_new_data, sched_audio_video,
               sched_num_words, busy, timeout_err, frames_sent
    );

    modport slave (
        output aud_req, aud_len, vid_req, vid_len, sched_tx_eof,
        input  aud_done, vid_done, sched_new_data, sched_audio_video,
               sched_num_words, busy, timeout_err, frames_sent
    );
endinterface

// File: rtl/eth_tx_source_arbiter.sv
// Round-robin arbiter sharing one Ethernet TX frame scheduler between the audio
// and video buffers, with per-frame watchdog, inter-frame gap and sent counter.
module eth_tx_source_arbiter #(
    parameter int IFG_CYCLES     = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_LEN        = 1024
) (
    input  logic                      clk_50mhz,
    input  logic                      eth_rstn,
    eth_tx_source_arbiter_if.master   arb
);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST   = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [10:0]   MAX_LEN_W = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, START, WAIT_EOF, GAP} state_t;

    state_t        state_reg;
    logic [1:0]    req_q_reg;            // bit 1 = audio, bit 0 = video
    logic [10:0]   len_q_reg [2];
    logic          last_served_reg;      // 1 = audio, 0 = video
    logic          eof_prev_reg;
    logic [WW-1:0] wd_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          aud_done_reg;
    logic          vid_done_reg;
    logic          new_data_reg;
    logic          av_reg;
    logic [10:0]   num_words_reg;
    logic          busy_reg;
    logic          timeout_reg;
    logic [15:0]   frames_reg;

    logic [10:0]   src_len [2];
    logic [10:0]   clamped_len [2];
    logic          grant_audio;
    logic          eof_edge;
    logic          wd_expired;

    assign src_len[1] = arb.aud_len;
    assign src_len[0] = arb.vid_len;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign clamped_len[gi] = (src_len[gi] > MAX_LEN_W) ? MAX_LEN_W : src_len[gi];
    end

    // On a tie the source that was not served last wins.
    assign grant_audio = (req_q_reg == 2'b11) ? !last_served_reg : req_q_reg[1];
    assign eof_edge    = arb.sched_tx_eof && !eof_prev_reg;
    assign wd_expired  = (wd_cnt_reg == WD_LAST);

    always_ff @(posedge clk_50mhz) begin
        if (!eth_rstn) begin
            state_reg       <= IDLE;
            req_q_reg       <= 2'b00;
            len_q_reg[0]    <= '0;
            len_q_reg[1]    <= '0;
            last_served_reg <= 1'b0;
            eof_prev_reg    <= 1'b0;
            wd_cnt_reg      <= '0;
            gap_cnt_reg     <= '0;
            aud_done_reg    <= 1'b0;
            vid_done_reg    <= 1'b0;
            new_data_reg    <= 1'b0;
            av_reg          <= 1'b0;
            num_words_reg   <= '0;
            busy_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            frames_reg      <= '0;
        end else begin
            eof_prev_reg <= arb.sched_tx_eof;
            aud_done_reg <= 1'b0;
            vid_done_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            // Requests are only captured while idle so a buffer that drops its
            // request after done is never re-granted from a stale sample.
            req_q_reg    <= (state_reg == IDLE) ? {arb.aud_req, arb.vid_req} : 2'b00;
            len_q_reg[0] <= clamped_len[0];
            len_q_reg[1] <= clamped_len[1];

            case (state_reg)
                IDLE: begin
                    if (req_q_reg != 2'b00) begin
                        av_reg        <= grant_audio;
                        num_words_reg <= grant_audio ? len_q_reg[1] : len_q_reg[0];
                        new_data_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        wd_cnt_reg    <= '0;
                        state_reg     <= START;
                    end
                end
                START, WAIT_EOF: begin
                    if (state_reg == WAIT_EOF && eof_edge) begin
                        aud_done_reg    <= av_reg;
                        vid_done_reg    <= !av_reg;
                        frames_reg      <= frames_reg + 16'd1;
                        last_served_reg <= av_reg;
                        gap_cnt_reg     <= '0;
                        busy_reg        <= (IFG_CYCLES != 0);
                        state_reg       <= (IFG_CYCLES != 0) ? GAP : IDLE;
                    end else if (wd_expired) begin
                        timeout_reg     <= 1'b1;
                        last_served_reg <= av_reg;
                        new_data_reg    <= 1'b0;
                        gap_cnt_reg     <= '0;
                        busy_reg        <= (IFG_CYCLES != 0);
                        state_reg       <= (IFG_CYCLES != 0) ? GAP : IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                        if (state_reg == START && !arb.sched_tx_eof) begin
                            new_data_reg <= 1'b0;
                            state_reg    <= WAIT_EOF;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign arb.aud_done          = aud_done_reg;
    assign arb.vid_done          = vid_done_reg;
    assign arb.sched_new_data    = new_data_reg;
    assign arb.sched_audio_video = av_reg;
    assign arb.sched_num_words   = num_words_reg;
    assign arb.busy              = busy_reg;
    assign arb.timeout_err       = timeout_reg;
    assign arb.frames_sent       = frames_reg;
endmodule

// File: tb/tb_eth_tx_source_arbiter.sv
// Scoreboard bench: stimulus queues expected frame starts, done pulses and
// timeouts; a monitor pops and compares them as the arbiter produces them.
module tb_eth_tx_source_arbiter;
    localparam int IFG = 24;
    localparam int EV_START = 0, EV_DONE = 1, EV_TO = 2;

    typedef struct {
        int          kind;
        bit          src;
        logic [10:0] len;
        logic [15:0] fs;
    } exp_evt_t;

    logic clk;
    logic rstn;
    eth_tx_source_arbiter_if sif ();

    eth_tx_source_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(4096), .MAX_LEN(1024)) dut (
        .clk_50mhz (clk),
        .eth_rstn  (rstn),
        .arb       (sif)
    );

    exp_evt_t    expq [$];
    int          n_err = 0;
    int          n_checks = 0;
    logic [15:0] exp_fs = 0;
    int          sch_hold = 0;
    int          sch_delay = 10;
    bit          sch_busy = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input bit src, input logic [10:0] len);
        exp_evt_t e;
        if (kind == EV_DONE) exp_fs = exp_fs + 16'd1;
        e.kind = kind;
        e.src  = src;
        e.len  = len;
        e.fs   = exp_fs;
        expq.push_back(e);
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return sif.sched_new_data;
            1:       return sif.aud_done;
            2:       return sif.vid_done;
            3:       return sif.timeout_err;
            4:       return expq.size() == 0;
            5:       return !sif.busy && !sch_busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int budget, input string name, output int n);
        n = 0;
        n_checks++;
        while (!cond(kind)) begin
            if (n >= budget) begin
                n_err++;
                $display("FAIL wait_%s: got no event within %0d cycles, required one", name, budget);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Scheduler model: on a frame start it lowers eof (after an optional hold),
    // then raises it again sch_delay cycles later.
    initial begin
        sif.sched_tx_eof = 1'b1;
        forever begin
            @(negedge clk);
            if (sif.sched_new_data && sif.sched_tx_eof) begin
                sch_busy = 1;
                repeat (sch_hold) @(negedge clk);
                sif.sched_tx_eof = 1'b0;
                repeat (sch_delay) @(negedge clk);
                sif.sched_tx_eof = 1'b1;
                sch_busy = 0;
            end
        end
    end

    task automatic consume(input int kind, input bit src, input logic [10:0] len);
        exp_evt_t e;
        n_checks++;
        if (expq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d src=%0d len=%0d, required none", kind, src, len);
            return;
        end
        e = expq.pop_front();
        if (e.kind != kind || e.src != src || (kind == EV_START && e.len != len) ||
            sif.frames_sent !== e.fs) begin
            n_err++;
            $display("FAIL event: got kind=%0d src=%0d len=%0d frames=%0d, required kind=%0d src=%0d len=%0d frames=%0d",
                     kind, src, len, sif.frames_sent, e.kind, e.src, e.len, e.fs);
        end else begin
            $display("txn kind=%0d src=%0d len=%0d frames=%0d", kind, src, len, sif.frames_sent);
        end
    endtask

    // Monitor
    initial begin
        bit prev_nd = 0;
        bit end_valid = 0;
        int cyc = 0;
        int end_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                prev_nd = 0;
                end_valid = 0;
            end else begin
                if (sif.sched_new_data && !prev_nd) begin
                    if (end_valid) begin
                        n_checks++;
                        if (cyc - end_cyc <= IFG) begin
                            n_err++;
                            $display("FAIL ifg_gap: got=%0d cycles, required >%0d", cyc - end_cyc, IFG);
                        end
                    end
                    consume(EV_START, sif.sched_audio_video, sif.sched_num_words);
                end
                prev_nd = sif.sched_new_data;
                if (sif.aud_done) consume(EV_DONE, 1'b1, 11'd0);
                if (sif.vid_done) consume(EV_DONE, 1'b0, 11'd0);
                if (sif.timeout_err) consume(EV_TO, sif.sched_audio_video, 11'd0);
                if (sif.aud_done || sif.vid_done || sif.timeout_err) begin
                    end_valid = 1;
                    end_cyc = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        expq.delete();
        exp_fs = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_new_data"}, 32'(sif.sched_new_data), 0);
        chk({tag, "_av"},       32'(sif.sched_audio_video), 0);
        chk({tag, "_words"},    32'(sif.sched_num_words), 0);
        chk({tag, "_aud_done"}, 32'(sif.aud_done), 0);
        chk({tag, "_vid_done"}, 32'(sif.vid_done), 0);
        chk({tag, "_busy"},     32'(sif.busy), 0);
        chk({tag, "_timeout"},  32'(sif.timeout_err), 0);
        chk({tag, "_frames"},   32'(sif.frames_sent), 0);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        sif.aud_req = 0; sif.aud_len = 0;
        sif.vid_req = 0; sif.vid_len = 0;
        do_reset();
        chk_all_zero("reset");

        // 1: single audio frame, eof 2000 cycles after the drop
        sch_delay = 2000;
        push(EV_START, 1'b1, 11'd100);
        push(EV_DONE, 1'b1, 11'd0);
        sif.aud_len = 11'd100;
        sif.aud_req = 1'b1;
        @(negedge clk);
        chk("t1_latency_n", 32'(sif.sched_new_data), 0);
        @(negedge clk);
        chk("t1_latency_n1", 32'(sif.sched_new_data), 1);
        wait_for(1, 2100, "t1_aud_done", n);
        chk("t1_eof_to_done", n, 2001);
        sif.aud_req = 1'b0;
        chk("t1_busy_gap0", 32'(sif.busy), 1);
        repeat (23) @(negedge clk);
        chk("t1_busy_gap23", 32'(sif.busy), 1);
        @(negedge clk);
        chk("t1_busy_idle", 32'(sif.busy), 0);
        wait_for(5, 100, "t1_idle", n);

        // 2: both requesting, strict alternation from a fresh reset
        sch_delay = 10;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(EV_START, 1'b1, 11'd64);
            push(EV_DONE, 1'b1, 11'd0);
            push(EV_START, 1'b0, 11'd200);
            push(EV_DONE, 1'b0, 11'd0);
        end
        sif.aud_len = 11'd64;  sif.aud_req = 1'b1;
        sif.vid_len = 11'd200; sif.vid_req = 1'b1;
        wait_for(4, 600, "t2_six_frames", n);
        sif.aud_req = 1'b0; sif.vid_req = 1'b0;
        chk("t2_frames", 32'(sif.frames_sent), 6);
        repeat (40) @(negedge clk);

        // 3: length clamp and zero-length frame
        push(EV_START, 1'b0, 11'd1024);
        push(EV_DONE, 1'b0, 11'd0);
        sif.vid_len = 11'd1500; sif.vid_req = 1'b1;
        wait_for(4, 100, "t3_clamp", n);
        sif.vid_req = 1'b0;
        wait_for(5, 100, "t3_idle_a", n);
        push(EV_START, 1'b0, 11'd0);
        push(EV_DONE, 1'b0, 11'd0);
        sif.vid_len = 11'd0; sif.vid_req = 1'b1;
        wait_for(4, 100, "t3_zero_len", n);
        sif.vid_req = 1'b0;
        wait_for(5, 100, "t3_idle_b", n);

        // 4: scheduler keeps eof high for the first 50 START cycles
        sch_hold = 49;
        push(EV_START, 1'b1, 11'd300);
        push(EV_DONE, 1'b1, 11'd0);
        sif.aud_len = 11'd300; sif.aud_req = 1'b1;
        wait_for(0, 100, "t4_start", n);
        n = 0;
        while (sif.sched_new_data && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t4_new_data_width", n, 50);
        sch_hold = 0;
        wait_for(4, 100, "t4_done", n);
        sif.aud_req = 1'b0;
        wait_for(5, 100, "t4_idle", n);

        // 5: watchdog on a video frame, then audio gets the next turn
        sch_delay = 5000;
        push(EV_START, 1'b0, 11'd70);
        push(EV_TO, 1'b0, 11'd0);
        push(EV_START, 1'b1, 11'd50);
        push(EV_DONE, 1'b1, 11'd0);
        sif.aud_len = 11'd50; sif.vid_len = 11'd70;
        sif.aud_req = 1'b1;   sif.vid_req = 1'b1;
        wait_for(0, 100, "t5_start", n);
        wait_for(3, 5000, "t5_timeout", n);
        chk("t5_timeout_cycles", n, 4096);
        wait_for(4, 2000, "t5_next_frame", n);
        sif.aud_req = 1'b0; sif.vid_req = 1'b0;
        wait_for(5, 200, "t5_idle", n);

        // 6: reset in WAIT_EOF, then a tie goes to audio
        sch_delay = 300;
        push(EV_START, 1'b1, 11'd40);
        sif.aud_len = 11'd40; sif.aud_req = 1'b1;
        wait_for(0, 100, "t6_start", n);
        repeat (20) @(negedge clk);
        sif.aud_req = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        expq.delete();
        exp_fs = 0;
        chk_all_zero("t6_reset");
        wait_for(5, 400, "t6_sched_idle", n);
        sch_delay = 10;
        push(EV_START, 1'b1, 11'd33);
        push(EV_DONE, 1'b1, 11'd0);
        sif.aud_len = 11'd33; sif.vid_len = 11'd44;
        sif.aud_req = 1'b1;   sif.vid_req = 1'b1;
        wait_for(4, 100, "t6_tie", n);
        sif.aud_req = 1'b0; sif.vid_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_frames", 32'(sif.frames_sent), 1);
        chk("end_queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
